// File: rtl/rtc_calendar_core.sv
// Synchronous BCD real-time clock/calendar (centiseconds to 4-digit year) with a digit-edit adjust mode.
// Optional alarm compare output enabled by defining RTC_ALARM_EN.
module rtc_calendar_core #(
  parameter int         CLK_HZ       = 50_000_000,
  parameter int         TICK_HZ      = 100,
  parameter logic [7:0] RESET_YEAR_H = 8'h20,
  parameter logic [7:0] RESET_YEAR_L = 8'h00
) (
  input  logic       CLOCK_50,
  input  logic       rst_n,
  input  logic       adjust,
  input  logic [3:0] select,
  input  logic       add,
  input  logic       clr,
`ifdef RTC_ALARM_EN
  input  logic       alarm_on,
  input  logic [5:0] alarm_hour,
  input  logic [6:0] alarm_minute,
  output logic       alarm,
`endif
  output logic [7:0] millisecond,
  output logic [6:0] second,
  output logic [6:0] minute,
  output logic [5:0] hour,
  output logic [5:0] day,
  output logic [4:0] month,
  output logic [7:0] year_l,
  output logic [7:0] year_h,
  output logic       sec_pulse,
  output logic       leap
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW  = $clog2(DIV);

  function automatic logic div4(input logic [7:0] b);
    if (b[4]) return (b[3:0] == 4'h2) || (b[3:0] == 4'h6);
    else      return (b[3:0] == 4'h0) || (b[3:0] == 4'h4) || (b[3:0] == 4'h8);
  endfunction

  function automatic logic [5:0] dim_of(input logic [4:0] m, input logic lp);
    case (m)
      5'h04, 5'h06, 5'h09, 5'h11: return 6'h30;
      5'h02:                      return lp ? 6'h29 : 6'h28;
      default:                    return 6'h31;
    endcase
  endfunction

  // Returns {carry, next}: at maxv wraps to minv with carry, otherwise BCD +1.
  function automatic logic [8:0] bcd_step(input logic [7:0] v, input logic [7:0] maxv,
                                          input logic [7:0] minv);
    if (v == maxv)            return {1'b1, minv};
    else if (v[3:0] == 4'h9)  return {1'b0, v[7:4] + 4'h1, 4'h0};
    else                      return {1'b0, v[7:4], v[3:0] + 4'h1};
  endfunction

  logic          adjust_p0, adjust_p1;
  logic          add_p0, add_p1, add_p2;
  logic          clr_p0, clr_p1, clr_p2;
  logic          add_stb, clr_stb, edit;
  logic [PW-1:0] pre;
  logic          tick;
  logic [5:0]    dim_cur;

  logic [7:0] cs_n, yl_n, yh_n;
  logic [6:0] sec_n, min_n;
  logic [5:0] hour_n, day_n;
  logic [4:0] month_n;
  logic [8:0] st_cs, st_s, st_m, st_h, st_d, st_mo, st_yl, st_yh;
  logic [3:0] cur_dig, dmax, new_dig;
  logic       unused;

  // Input synchronisers and button edge detection
  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      adjust_p0 <= 1'b0; adjust_p1 <= 1'b0;
      add_p0 <= 1'b0; add_p1 <= 1'b0; add_p2 <= 1'b0;
      clr_p0 <= 1'b0; clr_p1 <= 1'b0; clr_p2 <= 1'b0;
    end else begin
      adjust_p0 <= adjust; adjust_p1 <= adjust_p0;
      add_p0 <= add; add_p1 <= add_p0; add_p2 <= add_p1;
      clr_p0 <= clr; clr_p1 <= clr_p0; clr_p2 <= clr_p1;
    end
  end

  assign add_stb = add_p1 & ~add_p2;
  assign clr_stb = clr_p1 & ~clr_p2;
  assign edit    = adjust_p1 & (add_stb | clr_stb);

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n)                         pre <= '0;
    else if (adjust_p1 || pre == PW'(DIV - 1)) pre <= '0;
    else                                pre <= pre + PW'(1);
  end

  assign tick    = ~adjust_p1 && (pre == PW'(DIV - 1));
  assign leap    = (year_l != 8'h00) ? div4(year_l) : div4(year_h);
  assign dim_cur = dim_of(month, leap);

  always_comb begin
    cs_n = millisecond; sec_n = second; min_n = minute; hour_n = hour;
    day_n = day; month_n = month; yl_n = year_l; yh_n = year_h;
    st_cs = bcd_step(millisecond, 8'h99, 8'h00);
    st_s  = bcd_step({1'b0, second}, 8'h59, 8'h00);
    st_m  = bcd_step({1'b0, minute}, 8'h59, 8'h00);
    st_h  = bcd_step({2'b0, hour}, 8'h23, 8'h00);
    st_d  = bcd_step({2'b0, day}, {2'b0, dim_cur}, 8'h01);
    st_mo = bcd_step({3'b0, month}, 8'h12, 8'h01);
    st_yl = bcd_step(year_l, 8'h99, 8'h00);
    st_yh = bcd_step(year_h, 8'h99, 8'h00);
    dmax  = 4'h9;
    case (select)
      4'd0:    cur_dig = millisecond[3:0];
      4'd1:    cur_dig = millisecond[7:4];
      4'd2:    cur_dig = second[3:0];
      4'd3:    begin cur_dig = {1'b0, second[6:4]}; dmax = 4'h5; end
      4'd4:    cur_dig = minute[3:0];
      4'd5:    begin cur_dig = {1'b0, minute[6:4]}; dmax = 4'h5; end
      4'd6:    cur_dig = hour[3:0];
      4'd7:    begin cur_dig = {2'b0, hour[5:4]}; dmax = 4'h3; end
      4'd8:    cur_dig = day[3:0];
      4'd9:    begin cur_dig = {2'b0, day[5:4]}; dmax = 4'h3; end
      4'd10:   cur_dig = month[3:0];
      4'd11:   begin cur_dig = {3'b0, month[4]}; dmax = 4'h1; end
      4'd12:   cur_dig = year_l[3:0];
      4'd13:   cur_dig = year_l[7:4];
      4'd14:   cur_dig = year_h[3:0];
      default: cur_dig = year_h[7:4];
    endcase
    new_dig = clr_stb ? 4'h0 : ((cur_dig == dmax) ? 4'h0 : cur_dig + 4'h1);

    if (tick) begin
      // Whole carry chain resolves in this one cycle
      cs_n = st_cs[7:0];
      if (st_cs[8]) begin
        sec_n = st_s[6:0];
        if (st_s[8]) begin
          min_n = st_m[6:0];
          if (st_m[8]) begin
            hour_n = st_h[5:0];
            if (st_h[8]) begin
              day_n = st_d[5:0];
              if (st_d[8]) begin
                month_n = st_mo[4:0];
                if (st_mo[8]) begin
                  yl_n = st_yl[7:0];
                  if (st_yl[8]) yh_n = st_yh[7:0];
                end
              end
            end
          end
        end
      end
    end else if (edit) begin
      case (select)
        4'd0:    cs_n[3:0]    = new_dig;
        4'd1:    cs_n[7:4]    = new_dig;
        4'd2:    sec_n[3:0]   = new_dig;
        4'd3:    sec_n[6:4]   = new_dig[2:0];
        4'd4:    min_n[3:0]   = new_dig;
        4'd5:    min_n[6:4]   = new_dig[2:0];
        4'd6:    hour_n[3:0]  = new_dig;
        4'd7:    hour_n[5:4]  = new_dig[1:0];
        4'd8:    day_n[3:0]   = new_dig;
        4'd9:    day_n[5:4]   = new_dig[1:0];
        4'd10:   month_n[3:0] = new_dig;
        4'd11:   month_n[4]   = new_dig[0];
        4'd12:   yl_n[3:0]    = new_dig;
        4'd13:   yl_n[7:4]    = new_dig;
        4'd14:   yh_n[3:0]    = new_dig;
        default: yh_n[7:4]    = new_dig;
      endcase
      if (hour_n > 6'h23) hour_n = 6'h00;
      if (day_n == 6'h00 || day_n > dim_cur) day_n = 6'h01;
      if (month_n == 5'h00 || month_n > 5'h12) month_n = 5'h01;
    end else if (day > dim_cur) begin
      day_n = dim_cur;
    end
  end

  assign unused = ^{st_s[7], st_m[7], st_h[7:6], st_d[7:6], st_mo[7:5], st_yh[8]};

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      millisecond <= 8'h00; second <= 7'h00; minute <= 7'h00; hour <= 6'h00;
      day <= 6'h01; month <= 5'h01; year_l <= RESET_YEAR_L; year_h <= RESET_YEAR_H;
      sec_pulse <= 1'b0;
    end else begin
      millisecond <= cs_n; second <= sec_n; minute <= min_n; hour <= hour_n;
      day <= day_n; month <= month_n; year_l <= yl_n; year_h <= yh_n;
      sec_pulse <= tick && (millisecond == 8'h99);
    end
  end

`ifdef RTC_ALARM_EN
  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) alarm <= 1'b0;
    else        alarm <= tick && alarm_on && (hour_n == alarm_hour) && (min_n == alarm_minute)
                         && (sec_n == 7'h00) && (cs_n == 8'h00);
  end
`endif

endmodule

// File: tb/tb_rtc_calendar_core.sv
// Directed bench for rtc_calendar_core at CLK_HZ=1000, TICK_HZ=100 (one tick per 10 clocks).
module tb_rtc_calendar_core;
  logic       CLOCK_50 = 1'b0;
  logic       rst_n, adjust, add, clr;
  logic [3:0] select;
  logic [7:0] millisecond, year_l, year_h;
  logic [6:0] second, minute;
  logic [5:0] hour, day;
  logic [4:0] month;
  logic       sec_pulse, leap;
`ifdef RTC_ALARM_EN
  logic       alarm_on, alarm;
  logic [5:0] alarm_hour;
  logic [6:0] alarm_minute;
`endif
  int checks = 0;
  int errors = 0;
  int pulses;

  rtc_calendar_core #(.CLK_HZ(1000), .TICK_HZ(100)) dut (
    .CLOCK_50(CLOCK_50), .rst_n(rst_n), .adjust(adjust), .select(select), .add(add), .clr(clr),
`ifdef RTC_ALARM_EN
    .alarm_on(alarm_on), .alarm_hour(alarm_hour), .alarm_minute(alarm_minute), .alarm(alarm),
`endif
    .millisecond(millisecond), .second(second), .minute(minute), .hour(hour), .day(day),
    .month(month), .year_l(year_l), .year_h(year_h), .sec_pulse(sec_pulse), .leap(leap)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic clk(input int n);
    repeat (n) @(posedge CLOCK_50);
    @(negedge CLOCK_50);
  endtask

  task automatic press(input logic [3:0] sel, input logic a, input logic c);
    select = sel; add = a; clr = c;
    clk(4);
    add = 1'b0; clr = 1'b0;
    clk(4);
  endtask

  task automatic set_digit(input logic [3:0] sel, input int n);
    press(sel, 1'b0, 1'b1);
    for (int i = 0; i < n; i++) press(sel, 1'b1, 1'b0);
  endtask

  task automatic reset_to(input logic adj);
    rst_n = 1'b0; adjust = adj; add = 1'b0; clr = 1'b0; select = 4'd0;
`ifdef RTC_ALARM_EN
    alarm_on = 1'b0; alarm_hour = 6'h00; alarm_minute = 7'h00;
`endif
    clk(2);
    rst_n = 1'b1;
  endtask

  task automatic preload_last_cs;
    set_digit(4'd7, 2); set_digit(4'd6, 3);
    set_digit(4'd5, 5); set_digit(4'd4, 9);
    set_digit(4'd3, 5); set_digit(4'd2, 9);
    set_digit(4'd1, 9); set_digit(4'd0, 9);
  endtask

  initial begin
    // Reset values, then free run
    reset_to(1'b0);
    rst_n = 1'b0; clk(1);
    chk("rst_cs", millisecond, 8'h00);
    chk("rst_sec", second, 7'h00);
    chk("rst_min", minute, 7'h00);
    chk("rst_hour", hour, 6'h00);
    chk("rst_day", day, 6'h01);
    chk("rst_month", month, 5'h01);
    chk("rst_year", {year_h, year_l}, 16'h2000);
    chk("rst_pulse", sec_pulse, 1'b0);
    chk("rst_leap", leap, 1'b1);
    rst_n = 1'b1;
    clk(9);
    chk("run9_cs", millisecond, 8'h00);
    clk(1);
    chk("run10_cs", millisecond, 8'h01);
    pulses = 0;
    for (int i = 0; i < 990; i++) begin
      clk(1);
      if (sec_pulse) pulses++;
    end
    chk("run1000_sec", second, 7'h01);
    chk("run1000_cs", millisecond, 8'h00);
    chk("run1000_pulses", pulses, 1);
    #2 rst_n = 1'b0;
    #1 chk("async_rst_sec", second, 7'h00);

    // 1999-12-31 23:59:59.99 rolls into 2000-01-01
    reset_to(1'b1); clk(3);
    set_digit(4'd11, 1); set_digit(4'd10, 2);
    set_digit(4'd9, 3); set_digit(4'd8, 1);
    preload_last_cs();
    set_digit(4'd15, 1); set_digit(4'd14, 9); set_digit(4'd13, 9); set_digit(4'd12, 9);
    chk("pre99_time", {hour, 1'b0, minute, 1'b0, second, millisecond}, 32'h23595999);
    chk("pre99_date", {year_h, year_l, 2'b0, day, 3'b0, month}, 32'h19993112);
    chk("pre99_leap", leap, 1'b0);
    adjust = 1'b0;
    clk(11);
    chk("first_tick_not_early", millisecond, 8'h99);
    clk(1);
    chk("ny_time", {hour, 1'b0, minute, 1'b0, second, millisecond}, 32'h00000000);
    chk("ny_date", {year_h, year_l, 2'b0, day, 3'b0, month}, 32'h20000101);
    chk("ny_leap", leap, 1'b1);
    chk("ny_pulse", sec_pulse, 1'b1);
    clk(1);
    chk("ny_pulse_one_cycle", sec_pulse, 1'b0);

    // 2100-02-28 is not leap: next day is 03-01
    reset_to(1'b1); clk(3);
    set_digit(4'd14, 1);
    set_digit(4'd10, 1);
    set_digit(4'd9, 2); set_digit(4'd8, 8);
    preload_last_cs();
    chk("y2100_leap", leap, 1'b0);
    chk("y2100_pre_day", day, 6'h28);
    adjust = 1'b0; clk(12);
    chk("y2100_date", {year_h, year_l, 2'b0, day, 3'b0, month}, 32'h21000103);
    chk("y2100_hour", hour, 6'h00);

    // 2000-02-28 is leap: next day is 02-29
    reset_to(1'b1); clk(3);
    set_digit(4'd10, 1);
    set_digit(4'd9, 2); set_digit(4'd8, 8);
    preload_last_cs();
    adjust = 1'b0; clk(12);
    chk("y2000_date", {year_h, year_l, 2'b0, day, 3'b0, month}, 32'h20002902);
    chk("y2000_leap", leap, 1'b1);

    // Month edit in 2023 clamps day 31 to 28 one clock after the month changes
    reset_to(1'b1); clk(3);
    set_digit(4'd13, 2); set_digit(4'd12, 3);
    set_digit(4'd9, 3);
    chk("clamp_pre_day", day, 6'h31);
    select = 4'd10; add = 1'b1;
    clk(2);
    chk("edit_latency2_month", month, 5'h01);
    clk(1);
    chk("edit_latency3_month", month, 5'h02);
    chk("clamp_day_not_yet", day, 6'h31);
    clk(1);
    chk("clamp_day", day, 6'h28);
    add = 1'b0; clk(4);

    // Hour tens digit: 13 -> 23 -> 33 invalid -> 00; clr beats add
    set_digit(4'd7, 1); set_digit(4'd6, 3);
    chk("hour13", hour, 6'h13);
    press(4'd7, 1'b1, 1'b0);
    chk("hour23", hour, 6'h23);
    press(4'd7, 1'b1, 1'b0);
    chk("hour33_wrap", hour, 6'h00);
    press(4'd7, 1'b1, 1'b0);
    chk("hour10", hour, 6'h10);
    press(4'd7, 1'b1, 1'b1);
    chk("clr_wins", hour, 6'h00);
    press(4'd2, 1'b1, 1'b0); press(4'd2, 1'b1, 1'b0);
    press(4'd3, 1'b0, 1'b1);
    chk("sec_digits", second, 7'h02);

    // Edits ignored in run mode
    adjust = 1'b0; clk(3);
    press(4'd12, 1'b1, 1'b0);
    chk("run_ignores_add", year_l, 8'h23);
    press(4'd10, 1'b0, 1'b1);
    chk("run_ignores_clr", month, 5'h02);

    // 9999-12-31 wraps to 0000-01-01
    reset_to(1'b1); clk(3);
    set_digit(4'd11, 1); set_digit(4'd10, 2);
    set_digit(4'd9, 3); set_digit(4'd8, 1);
    preload_last_cs();
    set_digit(4'd15, 9); set_digit(4'd14, 9); set_digit(4'd13, 9); set_digit(4'd12, 9);
    adjust = 1'b0; clk(12);
    chk("y9999_wrap", {year_h, year_l, 2'b0, day, 3'b0, month}, 32'h00000101);
    chk("y0000_leap", leap, 1'b1);

`ifdef RTC_ALARM_EN
    // Alarm at 07:30 fires once in run mode, never in adjust mode
    for (int pass = 0; pass < 2; pass++) begin
      reset_to(1'b1); clk(3);
      set_digit(4'd6, 7); set_digit(4'd5, 2); set_digit(4'd4, 9);
      set_digit(4'd3, 5); set_digit(4'd2, 9); set_digit(4'd1, 9); set_digit(4'd0, 9);
      alarm_on = 1'b1; alarm_hour = 6'h07; alarm_minute = 7'h30;
      adjust = (pass == 1);
      pulses = 0;
      for (int i = 0; i < 40; i++) begin
        clk(1);
        if (alarm) pulses++;
      end
      chk(pass == 0 ? "alarm_run" : "alarm_adjust", pulses, (pass == 0) ? 1 : 0);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
